// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_stream_reader_pkg;

    // Reader FSM encoding, 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BURST     = 2'd1,
        ST_TAIL_WAIT = 2'd2
    } rd_state_e;

    // Width of the free-running pop counter.
    localparam int WORDS_READ_W = 16;

    // Bits needed to hold values 0..max_val (at least 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// 2-entry output buffer between the FIFO pop path and the downstream stream.
// Latency: a word pushed into an empty buffer is presented on m_data the next cycle.
// Backpressure: space drops when both entries are full and the head is not being taken.
//
// Ports: r_clk/rrst_n clock and async active-low reset; push_vld/push_dat write
// side; m_valid/m_ready/m_data downstream stream; space = a push is accepted now.
module fifo_skid_buffer #(
    parameter int MEMORY_WIDTH = 8
) (
    input  logic                    r_clk,
    input  logic                    rrst_n,
    input  logic                    push_vld,
    input  logic [MEMORY_WIDTH-1:0] push_dat,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [MEMORY_WIDTH-1:0] m_data,
    output logic                    space
);

    logic [1:0]              occ;
    logic [MEMORY_WIDTH-1:0] head_dat;
    logic [MEMORY_WIDTH-1:0] tail_dat;
    logic                    pop;

    assign pop     = m_valid && m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = head_dat;
    // A full buffer can still accept a word when the head leaves this cycle.
    assign space   = (occ < 2'd2) || pop;

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ      <= 2'd0;
            head_dat <= '0;
            tail_dat <= '0;
        end else begin
            case ({push_vld, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_dat <= push_dat;
                    end else begin
                        tail_dat <= push_dat;
                    end
                    if (occ != 2'd2) begin
                        occ <= occ + 2'd1;
                    end
                end
                2'b01: begin
                    head_dat <= tail_dat;
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (occ == 2'd1) begin
                        head_dat <= push_dat;
                    end else begin
                        head_dat <= tail_dat;
                        tail_dat <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO into a valid/ready stream: bursts when 2+ words wait, lone words after a timeout.
// Latency: one cycle from r_en to m_valid when the output buffer is empty.
// Backpressure: r_en is withheld whenever the 2-entry output buffer has no space.
//
// Ports: r_clk/rrst_n clock and async active-low reset; r_empty/r_almost_empty/rdata
// FIFO read side, r_en FIFO pop; m_valid/m_ready/m_data downstream stream;
// burst_active high in BURST; words_read counts pops since reset (wraps).
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int MEMORY_WIDTH = 8,
    parameter int ADDRESS_SIZE = 4,
    parameter int BURST_LEN    = 4,
    parameter int TAIL_TIMEOUT = 16
) (
    input  logic                    r_clk,
    input  logic                    rrst_n,
    input  logic                    r_empty,
    input  logic                    r_almost_empty,
    input  logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    r_en,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [MEMORY_WIDTH-1:0] m_data,
    output logic                    burst_active,
    output logic [WORDS_READ_W-1:0] words_read
);

    localparam int DEPTH     = 1 << ADDRESS_SIZE;
    // A burst never needs to be longer than the FIFO itself.
    localparam int BURST_EFF = (BURST_LEN > DEPTH) ? DEPTH : ((BURST_LEN < 1) ? 1 : BURST_LEN);
    localparam int CNT_W     = cnt_width(BURST_EFF);
    localparam int TMR_W     = cnt_width(TAIL_TIMEOUT - 1);

    localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'(BURST_EFF);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TAIL_TIMEOUT - 1);

    rd_state_e        state;
    logic [CNT_W-1:0] burst_cnt;
    logic [TMR_W-1:0] tail_tmr;
    logic             space;
    logic             tail_expired;

    assign tail_expired = (tail_tmr == TMR_LAST);
    assign burst_active = (state == ST_BURST);

    // Pop is combinational: it must react to r_empty and to downstream space in the same cycle.
    always_comb begin
        r_en = 1'b0;
        case (state)
            ST_BURST:     r_en = !r_empty && space;
            ST_TAIL_WAIT: r_en = !r_empty && r_almost_empty && tail_expired && space;
            default:      r_en = 1'b0;
        endcase
    end

    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= ST_IDLE;
            burst_cnt  <= '0;
            tail_tmr   <= '0;
            words_read <= '0;
        end else begin
            if (r_en) begin
                words_read <= words_read + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (!r_almost_empty) begin
                        state     <= ST_BURST;
                        burst_cnt <= BURST_LOAD;
                    end else if (!r_empty) begin
                        state    <= ST_TAIL_WAIT;
                        tail_tmr <= '0;
                    end
                end
                ST_BURST: begin
                    if (r_en) begin
                        burst_cnt <= burst_cnt - 1'b1;
                    end
                    if (r_empty || (r_en && burst_cnt == CNT_W'(1))) begin
                        state <= ST_IDLE;
                    end
                end
                ST_TAIL_WAIT: begin
                    if (r_empty) begin
                        state    <= ST_IDLE;
                        tail_tmr <= '0;
                    end else if (!r_almost_empty) begin
                        // A second word arrived: no point waiting out the timer.
                        state     <= ST_BURST;
                        burst_cnt <= BURST_LOAD;
                        tail_tmr  <= '0;
                    end else if (tail_expired) begin
                        // Timer stays saturated until the buffer can take the word.
                        if (space) begin
                            state    <= ST_IDLE;
                            tail_tmr <= '0;
                        end
                    end else begin
                        tail_tmr <= tail_tmr + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fifo_skid_buffer #(
        .MEMORY_WIDTH(MEMORY_WIDTH)
    ) u_skid (
        .r_clk    (r_clk),
        .rrst_n   (rrst_n),
        .push_vld (r_en),
        .push_dat (rdata),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .space    (space)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: FIFO model as a queue, output scoreboard,
// directed scenarios, random traffic, and a pop-counter wrap run on a second instance.
module tb_fifo_stream_reader;

    logic        r_clk = 1'b0;
    logic        rrst_n;
    logic        r_empty;
    logic        r_almost_empty;
    logic [7:0]  rdata;
    logic        r_en;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        burst_active;
    logic [15:0] words_read;

    logic        w_empty;
    logic        w_aempty;
    logic [7:0]  w_rdata;
    logic        w_ready;
    logic        w_r_en;
    logic        w_valid;
    logic [7:0]  w_data;
    logic        w_burst;
    logic [15:0] w_words;

    always #5 r_clk = ~r_clk;

    fifo_stream_reader #(
        .MEMORY_WIDTH(8), .ADDRESS_SIZE(4), .BURST_LEN(4), .TAIL_TIMEOUT(16)
    ) dut (
        .r_clk(r_clk), .rrst_n(rrst_n), .r_empty(r_empty), .r_almost_empty(r_almost_empty),
        .rdata(rdata), .r_en(r_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .burst_active(burst_active), .words_read(words_read)
    );

    fifo_stream_reader #(
        .MEMORY_WIDTH(8), .ADDRESS_SIZE(8), .BURST_LEN(256), .TAIL_TIMEOUT(16)
    ) u_wrap (
        .r_clk(r_clk), .rrst_n(rrst_n), .r_empty(w_empty), .r_almost_empty(w_aempty),
        .rdata(w_rdata), .r_en(w_r_en), .m_valid(w_valid), .m_ready(w_ready), .m_data(w_data),
        .burst_active(w_burst), .words_read(w_words)
    );

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  fq[$];      // words sitting in the modelled FIFO
    logic [7:0]  exp_q[$];   // words popped and not yet accepted downstream
    logic [7:0]  got_q[$];   // words observed on accepted handshakes
    logic [15:0] wr_model;
    logic [63:0] en_log;
    logic [63:0] ba_log;
    logic        s_vld;
    logic [7:0]  s_dat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic refresh_inputs();
        r_empty        = (fq.size() == 0);
        r_almost_empty = (fq.size() <= 1);
        rdata          = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic push_word(input logic [7:0] d);
        fq.push_back(d);
        refresh_inputs();
    endtask

    // One cycle: observe and score at the falling edge, apply the pop after the rising edge.
    task automatic tick();
        logic pop_pend;
        @(negedge r_clk);
        check("m_valid", m_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("m_data", m_data, exp_q[0]);
        check("words_read", words_read, wr_model);
        if (r_en) begin
            check("r_en_while_empty", r_empty, 1'b0);
            check("r_en_without_space", (exp_q.size() < 2) || m_ready, 1'b1);
        end
        en_log = {en_log[62:0], r_en};
        ba_log = {ba_log[62:0], burst_active};
        s_vld  = m_valid;
        s_dat  = m_data;
        pop_pend = r_en && rrst_n;
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            if (exp_q.size() != 0) exp_q.pop_front();
        end
        if (pop_pend) begin
            if (fq.size() != 0) exp_q.push_back(fq[0]);
            wr_model++;
        end
        @(posedge r_clk);
        #1;
        if (pop_pend && fq.size() != 0) fq.pop_front();
        refresh_inputs();
    endtask

    initial begin
        int cnt;
        bit done;
        bit ff_checked;

        rrst_n = 1'b1; m_ready = 1'b0; wr_model = '0; en_log = '0; ba_log = '0;
        w_empty = 1'b1; w_aempty = 1'b1; w_rdata = 8'h00; w_ready = 1'b1;
        refresh_inputs();
        #2 rrst_n = 1'b0;
        #1;
        check("rst_r_en", r_en, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_burst_active", burst_active, 1'b0);
        check("rst_words_read", words_read, 16'h0000);
        repeat (2) @(posedge r_clk);
        #1 rrst_n = 1'b1;

        // Six words, burst of four then a second burst of two.
        m_ready = 1'b1;
        got_q.delete();
        for (int i = 0; i < 6; i++) push_word(8'h10 + 8'(i));
        en_log = '0; ba_log = '0;
        repeat (10) tick();
        check("burst_r_en_pattern", en_log[9:0], 10'b0111101100);
        check("burst_active_pattern", ba_log[9:0], 10'b0111101110);
        check("burst_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) check("burst_order", got_q[i], 8'h10 + 8'(i));

        // Lone word drained after the tail timeout.
        push_word(8'hA5);
        en_log = '0;
        repeat (17) tick();
        check("tail_r_en_pattern", en_log[16:0], 17'h00001);
        tick();
        check("tail_m_valid", s_vld, 1'b1);
        check("tail_m_data", s_dat, 8'hA5);
        repeat (3) tick();

        // Second word arriving mid-wait promotes to a burst.
        got_q.delete();
        push_word(8'h5A);
        repeat (6) tick();
        push_word(8'h5B);
        en_log = '0; ba_log = '0;
        repeat (4) tick();
        check("promote_r_en_pattern", en_log[3:0], 4'b0110);
        check("promote_burst_active", ba_log[3:0], 4'b0111);
        en_log = '0;
        repeat (25) tick();
        check("promote_no_timeout_pop", en_log[24:0], 25'h0);
        check("promote_count", got_q.size(), 2);
        check("promote_first", got_q[0], 8'h5A);
        check("promote_second", got_q[1], 8'h5B);

        // Downstream stalled: only two pops fit, one more per accepted word.
        got_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
        en_log = '0;
        repeat (8) tick();
        check("stall_r_en_pattern", en_log[7:0], 8'b01100000);
        m_ready = 1'b1;
        en_log = '0;
        tick();
        m_ready = 1'b0;
        repeat (4) tick();
        check("stall_single_pop", en_log[4:0], 5'b10000);
        check("stall_one_out", got_q.size(), 1);
        m_ready = 1'b1;
        repeat (20) tick();
        check("stall_count", got_q.size(), 8);
        for (int i = 0; i < 8; i++) check("stall_order", got_q[i], 8'h20 + 8'(i));

        // Reset in the middle of a burst after two pops.
        for (int i = 0; i < 6; i++) push_word(8'h30 + 8'(i));
        repeat (3) tick();
        rrst_n = 1'b0;
        #1;
        check("midrst_m_valid", m_valid, 1'b0);
        check("midrst_words_read", words_read, 16'h0000);
        check("midrst_r_en", r_en, 1'b0);
        check("midrst_burst_active", burst_active, 1'b0);
        exp_q.delete(); got_q.delete(); wr_model = '0;
        repeat (2) tick();
        rrst_n = 1'b1;
        en_log = '0;
        repeat (10) tick();
        check("postrst_first_edge_no_pop", en_log[9], 1'b0);
        check("postrst_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check("postrst_order", got_q[i], 8'h32 + 8'(i));

        // Random traffic against the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (fq.size() < 16 && $urandom_range(0, 2) == 0) push_word(8'($urandom));
            tick();
        end
        m_ready = 1'b1;
        repeat (60) tick();
        check("random_fifo_drained", fq.size(), 0);
        check("random_buffer_drained", exp_q.size(), 0);

        // Pop counter wrap on the long-burst instance.
        cnt = 0; done = 1'b0; ff_checked = 1'b0;
        w_empty = 1'b0; w_aempty = 1'b0;
        for (int i = 0; i < 70000 && !done; i++) begin
            @(negedge r_clk);
            if (cnt == 65535 && !ff_checked) begin
                check("wrap_ffff", w_words, 16'hFFFF);
                ff_checked = 1'b1;
            end
            if (w_r_en) cnt++;
            if (cnt == 65536) done = 1'b1;
        end
        @(posedge r_clk);
        #1;
        w_empty = 1'b1; w_aempty = 1'b1;
        check("wrap_reached", done, 1'b1);
        @(negedge r_clk);
        check("wrap_zero", w_words, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
